// File: rtl/dsp_chain_drain.sv
// dsp_chain_drain: accumulates CFG_LEN signed products, saturates to DATA_W and queues results in a FIFO
module dsp_chain_drain #(
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 48,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              START,
  input  logic [LEN_W-1:0]  CFG_LEN,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_SAT,
  output logic              BUSY
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ACCUM, PUSH} state_t;
  state_t                             state_q;
  logic [ACC_W-1:0]                   acc_q;
  logic [LEN_W-1:0]                   cnt_q;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0]  mem_q;
  logic [FIFO_DEPTH-1:0]              sat_q;
  logic [PTR_W-1:0]                   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]                     count_q, count_d;
  logic                               hs, pop, push, full, sat;
  logic [DATA_W-1:0]                  sat_val;
  logic [ACC_W-DATA_W:0]              top;
  assign IN_READY  = state_q == ACCUM;
  assign BUSY      = state_q != IDLE;
  assign OUT_VALID = count_q != '0;
  assign OUT_DATA  = mem_q[rptr_q];
  assign OUT_SAT   = sat_q[rptr_q];
  assign hs        = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;
  assign full      = count_q == (PTR_W+1)'(FIFO_DEPTH);
  assign push      = state_q == PUSH && (!full || pop);
  // result fits in DATA_W only when all bits from the DATA_W sign bit upward agree
  assign top       = acc_q[ACC_W-1:DATA_W-1];
  assign sat       = !(&top || !(|top));
  assign sat_val   = !sat ? acc_q[DATA_W-1:0] :
                     acc_q[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  // dot-product control: sample length, accumulate beats, hand the result to the FIFO
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (START) begin
          acc_q   <= '0;
          cnt_q   <= CFG_LEN;
          state_q <= CFG_LEN == '0 ? PUSH : ACCUM;
        end
        ACCUM: if (hs) begin
          acc_q <= acc_q + {{(ACC_W-DATA_W){IN_DATA[DATA_W-1]}}, IN_DATA};
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_q <= PUSH;
        end
        PUSH: if (push) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // next-state for FIFO pointers and occupancy; power-of-2 depth lets pointers wrap freely
  always_comb begin
    wptr_d  = wptr_q + PTR_W'(push);
    rptr_d  = rptr_q + PTR_W'(pop);
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  // output FIFO storage and pointer registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      mem_q   <= '0;
      sat_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wptr_q] <= sat_val;
        sat_q[wptr_q] <= sat;
      end
    end
  end
endmodule

// File: tb/tb_dsp_chain_drain.sv
// tb_dsp_chain_drain: directed checks of accumulation, saturation, back-pressure and reset
module tb_dsp_chain_drain;
  logic        CLK = 0, RESETN = 1, START = 0, IN_VALID = 0, OUT_READY = 0;
  logic [15:0] CFG_LEN = '0;
  logic [31:0] IN_DATA = '0;
  logic        IN_READY, OUT_VALID, OUT_SAT, BUSY;
  logic [31:0] OUT_DATA;
  int          n_pass = 0, n_total = 0;

  dsp_chain_drain dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .CFG_LEN(CFG_LEN),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_SAT(OUT_SAT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic start(input logic [15:0] len);
    START = 1; CFG_LEN = len;
    tick();
    START = 0;
  endtask

  task automatic beat(input logic [31:0] d);
    IN_VALID = 1; IN_DATA = d;
    tick();
    IN_VALID = 0;
  endtask

  task automatic pop1();
    OUT_READY = 1;
    tick();
    OUT_READY = 0;
  endtask

  initial begin
    #3 RESETN = 0;
    #1;
    check("rst_in_ready", IN_READY, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_data", OUT_DATA, 0);
    check("rst_out_sat", OUT_SAT, 0);
    check("rst_busy", BUSY, 0);
    tick();
    RESETN = 1;
    tick();

    // basic sum 3-5+10+7 = 15
    start(4);
    check("basic_busy", BUSY, 1);
    check("basic_in_ready", IN_READY, 1);
    beat(3); beat(32'hFFFFFFFB); beat(10); beat(7);
    check("basic_push_ready", IN_READY, 0);
    check("basic_not_yet_valid", OUT_VALID, 0);
    check("basic_push_busy", BUSY, 1);
    tick();
    check("basic_valid", OUT_VALID, 1);
    check("basic_data", OUT_DATA, 15);
    check("basic_sat", OUT_SAT, 0);
    check("basic_idle", BUSY, 0);
    pop1();
    check("basic_empty", OUT_VALID, 0);

    // positive saturation
    start(3);
    beat(32'h7FFFFFFF); beat(32'h7FFFFFFF); beat(32'h7FFFFFFF);
    tick();
    check("psat_data", OUT_DATA, 32'h7FFFFFFF);
    check("psat_sat", OUT_SAT, 1);
    pop1();

    // negative saturation with IN_VALID gaps
    start(2);
    beat(32'h80000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nsat_gap_ready", IN_READY, 1);
    end
    beat(32'hFFFFFFFF);
    check("nsat_two_beats", IN_READY, 0);
    tick();
    check("nsat_data", OUT_DATA, 32'h80000000);
    check("nsat_sat", OUT_SAT, 1);
    pop1();
    check("nsat_one_entry", OUT_VALID, 0);

    // back-pressure: four results fill the FIFO, the fifth waits in PUSH
    OUT_READY = 0;
    for (int i = 1; i <= 5; i++) begin
      start(1);
      beat(32'(i));
      tick();
    end
    check("bp_hold_busy", BUSY, 1);
    check("bp_hold_ready", IN_READY, 0);
    check("bp_head", OUT_DATA, 1);
    tick();
    check("bp_still_busy", BUSY, 1);
    OUT_READY = 1;
    for (int k = 1; k <= 5; k++) begin
      check("bp_drain_valid", OUT_VALID, 1);
      check("bp_drain_data", OUT_DATA, 64'(k));
      tick();
    end
    OUT_READY = 0;
    check("bp_drained", OUT_VALID, 0);
    check("bp_idle", BUSY, 0);

    // zero length
    start(0);
    check("zero_busy", BUSY, 1);
    check("zero_ready", IN_READY, 0);
    tick();
    check("zero_valid", OUT_VALID, 1);
    check("zero_data", OUT_DATA, 0);
    check("zero_sat", OUT_SAT, 0);
    pop1();

    // START during ACCUM is ignored: 4+5+6 = 15
    start(3);
    beat(4);
    START = 1; CFG_LEN = 7; IN_VALID = 1; IN_DATA = 5;
    tick();
    START = 0; IN_VALID = 0;
    beat(6);
    tick();
    check("ign_data", OUT_DATA, 15);
    check("ign_sat", OUT_SAT, 0);
    pop1();
    tick();
    check("ign_no_extra", OUT_VALID, 0);
    check("ign_idle", BUSY, 0);

    // reset mid-operation with two results queued
    start(1); beat(100); tick();
    start(1); beat(200); tick();
    check("rmid_queued", OUT_VALID, 1);
    start(4);
    beat(1); beat(2);
    #2 RESETN = 0;
    #1;
    check("rmid_in_ready", IN_READY, 0);
    check("rmid_out_valid", OUT_VALID, 0);
    check("rmid_busy", BUSY, 0);
    tick(); tick();
    RESETN = 1;
    tick();
    start(1);
    beat(9);
    tick();
    check("rmid_fresh_valid", OUT_VALID, 1);
    check("rmid_fresh_data", OUT_DATA, 9);
    pop1();
    check("rmid_single", OUT_VALID, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
